block_spawn_scheduler: RTL

Central scheduler for the falling-block lanes of the piano game. Reads the note chart on every beat increment and allocates a free block slot in each lane that has a note. Judges key presses against the lowest in-window block in that lane, and keeps the hit and miss tallies. It sits between the beat counter/chart ROM and the per-slot falling-block instances, which it drives with one-cycle spawn and kill pulses.

---
 rtl/block_spawn_scheduler_pkg.sv | 26 ++
 rtl/block_spawn_scheduler_if.sv | 15 +
 rtl/block_spawn_scheduler_lane_slot_picker.sv | 47 ++++
 rtl/block_spawn_scheduler.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/block_spawn_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the piano block scheduler.
//   LANES/SLOTS     : lane count and block instances per lane (slot s = lane*SLOTS + k)
//   H_*             : block height constants (spawn, parked, hit window bounds)
//   SCORE_MAX/MISS_MAX : saturation limits of the tallies
package piano_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SLOTS = 2;
  localparam int unsigned H_W   = 10;

  localparam logic [H_W-1:0] H_SPAWN = 10'd120;
  localparam logic [H_W-1:0] H_PARK  = 10'd720;
  localparam logic [H_W-1:0] HIT_LO  = 10'd600;
  localparam logic [H_W-1:0] HIT_HI  = 10'd700;

  localparam logic [9:0] SCORE_MAX = 10'd999;
  localparam logic [7:0] MISS_MAX  = 8'd255;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  function automatic logic [3:0] count_ones(input logic [LANES-1:0] v);
    count_ones = '0;
    for (int unsigned i = 0; i < LANES; i++) count_ones = count_ones + 4'(v[i]);
  endfunction

endpackage

// File: rtl/block_spawn_scheduler_if.sv
// Slot bus between the scheduler and the falling-block instances.
//   slot_h : current height of every slot, slot s at [s*H_W +: H_W]
//   spawn  : one-cycle pulse, slot loads H_SPAWN
//   kill   : one-cycle pulse, slot forces H_PARK
// master = scheduler side, slave = block side.
interface block_spawn_scheduler_if
  import piano_pkg::*;
();
  logic [LANES*SLOTS*H_W-1:0] slot_h;
  logic [LANES*SLOTS-1:0]     spawn;
  logic [LANES*SLOTS-1:0]     kill;

  modport master (input slot_h, output spawn, output kill);
  modport slave  (output slot_h, input spawn, input kill);
endinterface

// File: rtl/block_spawn_scheduler_lane_slot_picker.sv
// Combinational per-lane slot selection.
//   h_i, reserved_i, killed_i : heights and status bits of the lane's slots
//   free_pick_o / none_free_o : lowest-index parked, unreserved slot (one-hot)
//   hit_pick_o  / none_hit_o  : active in-window slot with the largest height,
//                               lowest index on ties (one-hot)
module lane_slot_picker
  import piano_pkg::*;
(
  input  logic [SLOTS-1:0][H_W-1:0] h_i,
  input  logic [SLOTS-1:0]          reserved_i,
  input  logic [SLOTS-1:0]          killed_i,
  output logic [SLOTS-1:0]          free_pick_o,
  output logic                      none_free_o,
  output logic [SLOTS-1:0]          hit_pick_o,
  output logic                      none_hit_o
);
  logic [H_W-1:0] best_h;
  logic           free_found;
  logic           hit_found;

  always_comb begin
    free_pick_o = '0;
    hit_pick_o  = '0;
    free_found  = 1'b0;
    hit_found   = 1'b0;
    best_h      = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (!free_found && h_i[k] == H_PARK && !reserved_i[k]) begin
        free_pick_o[k] = 1'b1;
        free_found     = 1'b1;
      end
      // strict '>' keeps the earlier (lower-index) slot on equal heights
      if (h_i[k] != H_PARK && !killed_i[k] && !reserved_i[k] &&
          h_i[k] >= HIT_LO && h_i[k] <= HIT_HI &&
          (!hit_found || h_i[k] > best_h)) begin
        hit_pick_o    = '0;
        hit_pick_o[k] = 1'b1;
        hit_found     = 1'b1;
        best_h        = h_i[k];
      end
    end
  end

  assign none_free_o = !free_found;
  assign none_hit_o  = !hit_found;

endmodule

// File: rtl/block_spawn_scheduler.sv
// Central scheduler for the falling-block lanes: spawns blocks from the note
// chart on beat increments, judges key presses, detects escaped blocks and
// keeps the hit/miss tallies.
//   clk, rst_n (async, active-low), restart (sync clear), stop_or_endgame (freeze)
//   beat_cnt -> chart_addr (combinational), chart_mask, key_pulse
//   slots    : slot bus (slot_h in, spawn/kill out)
//   hit, miss, drop : one-cycle event pulses; score, miss_cnt : saturating tallies
module block_spawn_scheduler
  import piano_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  stop_or_endgame,
  input  logic [6:0]            beat_cnt,
  output logic [6:0]            chart_addr,
  input  logic [LANES-1:0]      chart_mask,
  input  logic [LANES-1:0]      key_pulse,
  block_spawn_scheduler_if.master slots,
  output logic [LANES-1:0]      hit,
  output logic [LANES-1:0]      miss,
  output logic                  drop,
  output logic [9:0]            score,
  output logic [7:0]            miss_cnt
);
  localparam int unsigned NS = LANES * SLOTS;

  state_e                  state_q, state_d;
  logic [6:0]              pre_beat_q;
  logic [NS-1:0]           reserved_q, reserved_d;
  logic [NS-1:0]           killed_q, killed_d;
  logic [NS-1:0]           was_active_q, was_active_d;
  logic [NS-1:0]           spawn_q, spawn_d, kill_q, kill_d;
  logic [LANES-1:0]        hit_q, hit_d, miss_q, miss_d;
  logic                    drop_q, drop_d;
  logic [9:0]              score_q, score_d;
  logic [7:0]              miss_cnt_q, miss_cnt_d;
  logic [10:0]             score_sum;
  logic [8:0]              miss_sum;

  logic [NS-1:0][H_W-1:0]  h;
  logic [NS-1:0]           parked;
  logic                    beat_add, live;
  logic [LANES-1:0][SLOTS-1:0] free_pick, hit_pick;
  logic [LANES-1:0]        none_free, none_hit;

  assign h          = slots.slot_h;
  assign chart_addr = beat_cnt;
  assign beat_add   = beat_cnt > pre_beat_q;
  // an event arriving together with stop_or_endgame is dropped
  assign live       = (state_q == RUN) && !stop_or_endgame;

  always_comb begin
    parked = '0;
    for (int unsigned s = 0; s < NS; s++) parked[s] = (h[s] == H_PARK);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_slot_picker u_picker (
      .h_i        (h[l*SLOTS +: SLOTS]),
      .reserved_i (reserved_q[l*SLOTS +: SLOTS]),
      .killed_i   (killed_q[l*SLOTS +: SLOTS]),
      .free_pick_o(free_pick[l]),
      .none_free_o(none_free[l]),
      .hit_pick_o (hit_pick[l]),
      .none_hit_o (none_hit[l])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat_add && !stop_or_endgame) state_d = RUN;
      RUN:     if (stop_or_endgame) state_d = HALT;
      HALT:    if (!stop_or_endgame) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spawn_d = '0;
    kill_d  = '0;
    hit_d   = '0;
    miss_d  = '0;
    drop_d  = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (live && beat_add && chart_mask[l]) begin
        if (none_free[l]) drop_d = 1'b1;
        else              spawn_d[l*SLOTS +: SLOTS] = free_pick[l];
      end
      if (live && key_pulse[l]) begin
        if (none_hit[l]) begin
          miss_d[l] = 1'b1;
        end else begin
          kill_d[l*SLOTS +: SLOTS] = hit_pick[l];
          hit_d[l] = 1'b1;
        end
      end
    end
    reserved_d   = reserved_q;
    killed_d     = killed_q;
    was_active_d = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      // escape: slot was active and unkilled last cycle and is parked now
      if (state_q != IDLE && parked[s] && was_active_q[s]) miss_d[s / SLOTS] = 1'b1;
      if (spawn_d[s])       reserved_d[s] = 1'b1;
      else if (!parked[s])  reserved_d[s] = 1'b0;
      if (kill_d[s])        killed_d[s] = 1'b1;
      else if (parked[s])   killed_d[s] = 1'b0;
      was_active_d[s] = !parked[s] && !killed_q[s] && !kill_d[s];
    end
  end

  always_comb begin
    score_sum  = {1'b0, score_q} + 11'(count_ones(hit_q));
    miss_sum   = {1'b0, miss_cnt_q} + 9'(count_ones(miss_q));
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == RUN) begin
      score_d    = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
      miss_cnt_d = (miss_sum > {1'b0, MISS_MAX}) ? MISS_MAX : miss_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || restart) begin
      state_q      <= IDLE;
      pre_beat_q   <= '0;
      reserved_q   <= '0;
      killed_q     <= '0;
      was_active_q <= '0;
      spawn_q      <= '0;
      kill_q       <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      drop_q       <= 1'b0;
      score_q      <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pre_beat_q   <= beat_cnt;
      reserved_q   <= reserved_d;
      killed_q     <= killed_d;
      was_active_q <= was_active_d;
      spawn_q      <= spawn_d;
      kill_q       <= kill_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      drop_q       <= drop_d;
      score_q      <= score_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign slots.spawn = spawn_q;
  assign slots.kill  = kill_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign drop        = drop_q;
  assign score       = score_q;
  assign miss_cnt    = miss_cnt_q;

endmodule
